// File: rtl/vend_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vend_pkg                                                         |
// | Shared state, status and opcode encodings for the vend block.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_CHECK = 2'd2
  } vend_state_e;

  typedef enum logic [1:0] {
    STAT_OK           = 2'd0,
    STAT_SOLD_OUT     = 2'd1,
    STAT_INSUFFICIENT = 2'd2,
    STAT_BAD_ID       = 2'd3
  } vend_status_e;

  typedef enum logic {
    OP_BUY  = 1'b0,
    OP_RSTK = 1'b1
  } vend_op_e;

  localparam logic [7:0] c_COUNT_MAX = 8'hFF;

  // Add a restock quantity to a stock count, clamping at the counter ceiling.
  function automatic logic [7:0] sat_count_add(input logic [7:0] count, input logic [7:0] qty);
    logic [8:0] sum;
    sum = {1'b0, count} + {1'b0, qty};
    return sum[8] ? c_COUNT_MAX : sum[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/vend_txn_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vend_txn_ctrl                                                    |
// | Purchase/restock transaction controller for an external store.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module vend_txn_ctrl
  import vend_pkg::*;
#(
  parameter int MAX_ITEMS = 1024,
  parameter int AW        = $clog2(MAX_ITEMS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          buy_valid,
  output logic          buy_ready,
  input  logic [AW-1:0] buy_item,
  input  logic [15:0]   buy_paid,
  input  logic          rstk_valid,
  output logic          rstk_ready,
  input  logic [AW-1:0] rstk_item,
  input  logic [15:0]   rstk_price,
  input  logic [7:0]    rstk_qty,
  output logic          resp_valid,
  output logic [1:0]    resp_status,
  output logic [15:0]   resp_change,
  output logic          dispense,
  output logic [AW-1:0] read_addr,
  input  logic [15:0]   rd_item_price,
  input  logic [7:0]    rd_avail_count,
  output logic          write_en,
  output logic [AW-1:0] waddr,
  output logic [15:0]   item_price,
  output logic [7:0]    avail_count
);

  vend_state_e  r_state;
  vend_state_e  w_state_nxt;
  vend_op_e     r_op;
  logic [AW-1:0] r_item;
  logic [15:0]  r_paid;
  logic [15:0]  r_price;
  logic [7:0]   r_qty;

  logic         w_accept;
  logic         w_accept_rstk;
  logic         w_rsp_valid;
  vend_status_e w_status;
  logic [15:0]  w_change;
  logic         w_dispense;
  logic         w_wr;
  logic [15:0]  w_wr_price;
  logic [7:0]   w_wr_count;
  logic         w_bad_id;

  // With a power-of-two slot count every address is a valid slot.
  generate
    if (MAX_ITEMS < (1 << AW)) begin : g_bad_id_cmp
      assign w_bad_id = (int'(r_item) >= MAX_ITEMS);
    end else begin : g_bad_id_none
      assign w_bad_id = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    buy_ready     = 1'b0;
    rstk_ready    = 1'b0;
    w_accept      = 1'b0;
    w_accept_rstk = 1'b0;
    w_rsp_valid   = 1'b0;
    w_status      = STAT_OK;
    w_change      = 16'd0;
    w_dispense    = 1'b0;
    w_wr          = 1'b0;
    w_wr_price    = 16'd0;
    w_wr_count    = 8'd0;
    case (r_state)
      ST_IDLE: begin
        rstk_ready = 1'b1;
        buy_ready  = ~rstk_valid;
        if (rstk_valid) begin
          w_accept      = 1'b1;
          w_accept_rstk = 1'b1;
          w_state_nxt   = ST_READ;
        end else if (buy_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        w_state_nxt = ST_IDLE;
        w_rsp_valid = 1'b1;
        if (w_bad_id) begin
          w_status = STAT_BAD_ID;
        end else if (r_op == OP_RSTK) begin
          w_wr       = 1'b1;
          w_wr_price = r_price;
          w_wr_count = sat_count_add(rd_avail_count, r_qty);
        end else if (rd_avail_count == 8'd0) begin
          w_status = STAT_SOLD_OUT;
        end else if (r_paid < rd_item_price) begin
          w_status = STAT_INSUFFICIENT;
        end else begin
          w_change   = r_paid - rd_item_price;
          w_dispense = 1'b1;
          w_wr       = 1'b1;
          w_wr_price = rd_item_price;
          w_wr_count = rd_avail_count - 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= OP_BUY;
      r_item    <= '0;
      r_paid    <= 16'd0;
      r_price   <= 16'd0;
      r_qty     <= 8'd0;
      read_addr <= '0;
    end else if (w_accept) begin
      r_op      <= w_accept_rstk ? OP_RSTK : OP_BUY;
      r_item    <= w_accept_rstk ? rstk_item : buy_item;
      r_paid    <= buy_paid;
      r_price   <= rstk_price;
      r_qty     <= rstk_qty;
      read_addr <= w_accept_rstk ? rstk_item : buy_item;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid  <= 1'b0;
      resp_status <= 2'd0;
      resp_change <= 16'd0;
      dispense    <= 1'b0;
      write_en    <= 1'b0;
      waddr       <= '0;
      item_price  <= 16'd0;
      avail_count <= 8'd0;
    end else begin
      resp_valid  <= w_rsp_valid;
      resp_status <= w_status;
      resp_change <= w_change;
      dispense    <= w_dispense;
      write_en    <= w_wr;
      if (w_wr) begin
        waddr       <= r_item;
        item_price  <= w_wr_price;
        avail_count <= w_wr_count;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vend_txn_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_vend_txn_ctrl                                                 |
// | Directed + random bench with an item store and reference model. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_vend_txn_ctrl;

  localparam int MAX_ITEMS = 1000;
  localparam int AW        = $clog2(MAX_ITEMS);
  localparam int DEPTH     = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          buy_valid = 1'b0;
  logic          buy_ready;
  logic [AW-1:0] buy_item = '0;
  logic [15:0]   buy_paid = 16'd0;
  logic          rstk_valid = 1'b0;
  logic          rstk_ready;
  logic [AW-1:0] rstk_item = '0;
  logic [15:0]   rstk_price = 16'd0;
  logic [7:0]    rstk_qty = 8'd0;
  logic          resp_valid;
  logic [1:0]    resp_status;
  logic [15:0]   resp_change;
  logic          dispense;
  logic [AW-1:0] read_addr;
  logic [15:0]   rd_item_price;
  logic [7:0]    rd_avail_count;
  logic          write_en;
  logic [AW-1:0] waddr;
  logic [15:0]   item_price;
  logic [7:0]    avail_count;

  vend_txn_ctrl #(.MAX_ITEMS(MAX_ITEMS)) dut (
    .clk(clk), .rst_n(rst_n),
    .buy_valid(buy_valid), .buy_ready(buy_ready), .buy_item(buy_item), .buy_paid(buy_paid),
    .rstk_valid(rstk_valid), .rstk_ready(rstk_ready), .rstk_item(rstk_item),
    .rstk_price(rstk_price), .rstk_qty(rstk_qty),
    .resp_valid(resp_valid), .resp_status(resp_status), .resp_change(resp_change),
    .dispense(dispense), .read_addr(read_addr),
    .rd_item_price(rd_item_price), .rd_avail_count(rd_avail_count),
    .write_en(write_en), .waddr(waddr), .item_price(item_price), .avail_count(avail_count)
  );

  always #5 clk = ~clk;

  // Item store: synchronous read, data one clock after the address is sampled.
  logic [15:0] st_price [DEPTH] = '{default: 16'd0};
  logic [7:0]  st_cnt   [DEPTH] = '{default: 8'd0};
  always @(posedge clk) begin
    if (write_en) begin
      st_price[waddr] <= item_price;
      st_cnt[waddr]   <= avail_count;
    end
    rd_item_price  <= st_price[read_addr];
    rd_avail_count <= st_cnt[read_addr];
  end

  int checks = 0;
  int passes = 0;
  int ref_price [DEPTH] = '{default: 0};
  int ref_cnt   [DEPTH] = '{default: 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: the vending rules applied directly to the modelled store contents.
  task automatic predict(input bit rs, input int item, input int pp, input int qty,
                         output int st, output int chg, output int wr, output int np, output int nc);
    st = 0; chg = 0; wr = 0; np = 0; nc = 0;
    if (item >= MAX_ITEMS) st = 3;
    else if (rs) begin
      wr = 1; np = pp; nc = ref_cnt[item] + qty;
      if (nc > 255) nc = 255;
    end else if (ref_cnt[item] == 0) st = 1;
    else if (pp < ref_price[item]) st = 2;
    else begin
      chg = pp - ref_price[item]; wr = 1; np = ref_price[item]; nc = ref_cnt[item] - 1;
    end
  endtask

  // Called #1 after the third edge following acceptance.
  task automatic check_resp(input string tag, input bit rs, input int item, input int pp, input int qty);
    int st, chg, wr, np, nc;
    predict(rs, item, pp, qty, st, chg, wr, np, nc);
    chk({tag, ".resp_valid"}, resp_valid, 1);
    chk({tag, ".status"}, resp_status, st);
    chk({tag, ".change"}, resp_change, chg);
    chk({tag, ".dispense"}, dispense, (!rs && st == 0) ? 1 : 0);
    chk({tag, ".write_en"}, write_en, wr);
    if (wr != 0) begin
      chk({tag, ".waddr"}, waddr, item);
      chk({tag, ".wprice"}, item_price, np);
      chk({tag, ".wcount"}, avail_count, nc);
      ref_price[item] = np;
      ref_cnt[item]   = nc;
    end
  endtask

  task automatic check_after(input string tag, input int item);
    chk({tag, ".pulse_end"}, {29'd0, resp_valid, dispense, write_en}, 0);
    if (item < MAX_ITEMS) begin
      chk({tag, ".store_cnt"}, st_cnt[item], ref_cnt[item]);
      chk({tag, ".store_price"}, st_price[item], ref_price[item]);
    end
  endtask

  task automatic run_txn(input string tag, input bit rs, input int item, input int pp, input int qty);
    @(negedge clk);
    if (rs) begin
      rstk_valid = 1'b1; rstk_item = item[AW-1:0]; rstk_price = pp[15:0]; rstk_qty = qty[7:0];
    end else begin
      buy_valid = 1'b1; buy_item = item[AW-1:0]; buy_paid = pp[15:0];
    end
    #1 chk({tag, ".ready"}, rs ? rstk_ready : buy_ready, 1);
    @(posedge clk);
    #1 rstk_valid = 1'b0; buy_valid = 1'b0;
    chk({tag, ".no_early"}, resp_valid, 0);
    @(posedge clk);
    @(posedge clk);
    #1 check_resp(tag, rs, item, pp, qty);
    @(posedge clk);
    #1 check_after(tag, item);
  endtask

  initial begin
    int item, pp, qty;
    bit rs;

    repeat (3) @(posedge clk);
    #1 chk("rst.outputs", {read_addr, waddr, item_price, avail_count, resp_valid,
                           resp_status, resp_change, dispense, write_en} == '0, 1);
    chk("rst.buy_ready", buy_ready, 1);
    @(negedge clk) rst_n = 1'b1;

    run_txn("rstk5", 1, 5, 150, 3);
    run_txn("buy5_ok", 0, 5, 200, 0);
    chk("buy5.count2", st_cnt[5], 2);
    run_txn("buy7_soldout", 0, 7, 0, 0);
    run_txn("buy5_insuff", 0, 5, 149, 0);
    run_txn("rstk9_a", 1, 9, 10, 250);
    run_txn("rstk9_sat", 1, 9, 10, 10);
    chk("rstk9.count255", st_cnt[9], 255);
    run_txn("buy_badid", 0, 1005, 500, 0);
    run_txn("rstk_badid", 1, 1010, 7, 9);

    // Simultaneous requests: restock first, purchase three cycles later.
    @(negedge clk);
    rstk_valid = 1'b1; rstk_item = 10'd3; rstk_price = 16'd80; rstk_qty = 8'd4;
    buy_valid = 1'b1; buy_item = 10'd3; buy_paid = 16'd100;
    #1 chk("both.rstk_ready", rstk_ready, 1);
    chk("both.buy_ready", buy_ready, 0);
    @(posedge clk);
    #1 rstk_valid = 1'b0;
    chk("both.busy_ready", buy_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #1 check_resp("both.rstk", 1, 3, 80, 4);
    chk("both.buy_ready_idle", buy_ready, 1);
    @(posedge clk);
    #1 buy_valid = 1'b0;
    chk("both.no_early", resp_valid, 0);
    @(posedge clk);
    @(posedge clk);
    #1 check_resp("both.buy", 0, 3, 100, 0);
    @(posedge clk);
    #1 check_after("both.buy", 3);

    // Reset while the purchase sits in CHECK.
    @(negedge clk);
    buy_valid = 1'b1; buy_item = 10'd5; buy_paid = 16'd200;
    @(posedge clk);
    #1 buy_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("rstmid.outputs", {read_addr, waddr, item_price, avail_count, resp_valid,
                              resp_status, resp_change, dispense, write_en} == '0, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk("rstmid.quiet", {30'd0, resp_valid, write_en}, 0);
    end
    @(negedge clk) rst_n = 1'b1;
    chk("rstmid.store_cnt", st_cnt[5], ref_cnt[5]);
    run_txn("after_rst", 0, 5, 300, 0);

    for (int n = 0; n < 40; n++) begin
      rs   = ($urandom_range(0, 2) == 0);
      item = ($urandom_range(0, 9) == 0) ? 1000 + $urandom_range(0, 23) : $urandom_range(0, 15);
      if (rs) begin
        pp  = $urandom_range(1, 300);
        qty = $urandom_range(0, 255);
      end else begin
        pp  = (item < MAX_ITEMS) ? ref_price[item] + $urandom_range(0, 20) - 10 : $urandom_range(0, 400);
        if (pp < 0) pp = 0;
        qty = 0;
      end
      run_txn("rand", rs, item, pp, qty);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
